// File: rtl/dm_byteen_ram.sv
// Word-organised data memory with per-byte write enables, a post-reset clear
// sequencer, a sticky out-of-range flag and a registered store trace.
module dm_byteen_ram #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] m_data_rdata,
  output logic        busy,
  output logic        oor_err,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  logic [0:0]            state, state_next;
  logic [ADDR_WIDTH-1:0] clr_ptr, clr_ptr_next;
  logic [31:0]           mem [DEPTH];

  logic [31:0]           offset;
  logic [31:0]           off_word;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           old_word;
  logic [31:0]           merged;
  logic                  store_acc;
  logic                  store_oor;

  // Address decode: wrap-around below the base counts as out of range
  always_comb begin
    offset   = m_data_addr - BASE_ADDR;
    off_word = offset >> 2;
    in_range = (m_data_addr >= BASE_ADDR) && (off_word < 32'(DEPTH));
    idx      = off_word[ADDR_WIDTH-1:0];
  end

  // Next-state, clear pointer, store acceptance and byte merge
  always_comb begin
    state_next   = state;
    clr_ptr_next = clr_ptr;
    store_acc    = 1'b0;
    store_oor    = 1'b0;
    old_word     = mem[idx];
    merged       = old_word;
    for (int i = 0; i < 4; i++) begin
      if (m_data_byteen[i]) merged[8*i +: 8] = m_data_wdata[8*i +: 8];
    end
    case (state)
      CLEAR: begin
        clr_ptr_next = clr_ptr + ADDR_WIDTH'(1);
        if (clr_ptr == LAST_IDX) state_next = READY;
      end
      default: begin
        store_acc = (m_data_byteen != 4'b0000) && in_range;
        store_oor = (m_data_byteen != 4'b0000) && !in_range;
      end
    endcase
  end

  // Combinational read; nothing is visible while clearing or out of range
  always_comb begin
    m_data_rdata = 32'h0;
    if (state == READY && in_range) m_data_rdata = old_word;
  end

  // State register, sticky error flag and store trace
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= CLEAR;
      clr_ptr     <= '0;
      busy        <= 1'b1;
      oor_err     <= 1'b0;
      trace_valid <= 1'b0;
      trace_pc    <= 32'h0;
      trace_addr  <= 32'h0;
      trace_data  <= 32'h0;
    end else begin
      state       <= state_next;
      clr_ptr     <= clr_ptr_next;
      busy        <= (state_next == CLEAR);
      trace_valid <= store_acc;
      if (store_oor) oor_err <= 1'b1;
      if (store_acc) begin
        trace_pc   <= m_inst_addr;
        trace_addr <= BASE_ADDR + (32'(idx) << 2);
        trace_data <= merged;
      end
    end
  end

  // Memory array: clear sequencer write or merged store, no reset
  always_ff @(posedge clk) begin
    if (state == CLEAR && reset) begin
      mem[clr_ptr] <= 32'h0;
    end else if (store_acc) begin
      mem[idx] <= merged;
    end
  end

endmodule

// File: tb/tb_dm_byteen_ram.sv
// Directed bench for dm_byteen_ram with a 16-word memory.
module tb_dm_byteen_ram;

  logic        clk;
  logic        reset;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_rdata;
  logic        busy;
  logic        oor_err;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;

  int n_checks = 0;
  int n_errors = 0;

  dm_byteen_ram #(.ADDR_WIDTH(4), .BASE_ADDR(32'h0000_0000)) dut (
    .clk          (clk),
    .reset        (reset),
    .m_data_addr  (m_data_addr),
    .m_data_wdata (m_data_wdata),
    .m_data_byteen(m_data_byteen),
    .m_inst_addr  (m_inst_addr),
    .m_data_rdata (m_data_rdata),
    .busy         (busy),
    .oor_err      (oor_err),
    .trace_valid  (trace_valid),
    .trace_pc     (trace_pc),
    .trace_addr   (trace_addr),
    .trace_data   (trace_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count edges until busy drops, bounded
  task automatic wait_clear(input string tag);
    int cnt = 0;
    while (busy && cnt < 100) begin
      step();
      cnt++;
    end
    check(tag, 32'(cnt), 32'd16);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [31:0] pc);
    m_data_addr   = a;
    m_data_wdata  = d;
    m_data_byteen = be;
    m_inst_addr   = pc;
  endtask

  logic [31:0] sa [3];
  logic [31:0] sd [3];

  initial begin
    reset = 1'b1;
    store(32'h0, 32'h0, 4'b0000, 32'h0);
    #1 reset = 1'b0;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_oor", 32'(oor_err), 32'd0);
    check("rst_tv", 32'(trace_valid), 32'd0);
    check("rst_tpc", trace_pc, 32'h0);
    check("rst_taddr", trace_addr, 32'h0);
    check("rst_tdata", trace_data, 32'h0);
    check("rst_rdata", m_data_rdata, 32'h0);

    // Byteen during clear is ignored
    reset = 1'b1;
    store(32'h8, 32'hFFFF_FFFF, 4'b1111, 32'h50);
    step();
    check("clr_no_trace", 32'(trace_valid), 32'd0);
    check("clr_rdata", m_data_rdata, 32'h0);
    m_data_byteen = 4'b0000;
    begin
      int cnt = 1;
      while (busy && cnt < 100) begin
        step();
        cnt++;
      end
      check("clear_len", 32'(cnt), 32'd16);
    end
    check("clr_oor", 32'(oor_err), 32'd0);
    for (int a = 0; a < 16; a++) begin
      m_data_addr = 32'(a * 4);
      #1 check("zero_rd", m_data_rdata, 32'h0);
    end

    // Partial byte merge
    store(32'h10, 32'hAABB_CCDD, 4'b1111, 32'h0FC);
    step();
    store(32'h10, 32'h1122_3344, 4'b0101, 32'h100);
    #1 check("rdw_old", m_data_rdata, 32'hAABB_CCDD);
    step();
    check("merge_rd", m_data_rdata, 32'hAA22_CC44);
    check("merge_tv", 32'(trace_valid), 32'd1);
    check("merge_taddr", trace_addr, 32'h10);
    check("merge_tdata", trace_data, 32'hAA22_CC44);
    check("merge_tpc", trace_pc, 32'h100);
    m_data_byteen = 4'b0000;
    step();
    check("idle_tv", 32'(trace_valid), 32'd0);
    check("hold_tdata", trace_data, 32'hAA22_CC44);

    // Unaligned address selects word
    store(32'h6, 32'hDEAD_BEEF, 4'b1111, 32'h104);
    step();
    check("unal_taddr", trace_addr, 32'h4);
    check("unal_tdata", trace_data, 32'hDEAD_BEEF);
    m_data_byteen = 4'b0000;
    m_data_addr   = 32'h4;
    #1 check("unal_rd", m_data_rdata, 32'hDEAD_BEEF);

    // Out-of-range store
    step();
    store(32'h40, 32'h1234_5678, 4'b1111, 32'h108);
    #1 check("oor_rd0", m_data_rdata, 32'h0);
    step();
    check("oor_set", 32'(oor_err), 32'd1);
    check("oor_no_tv", 32'(trace_valid), 32'd0);
    m_data_byteen = 4'b0000;
    step();
    step();
    check("oor_sticky", 32'(oor_err), 32'd1);
    check("oor_rd", m_data_rdata, 32'h0);
    m_data_addr = 32'h0;
    #1 check("oor_w0", m_data_rdata, 32'h0);

    // Back-to-back stores
    sa[0] = 32'h0; sa[1] = 32'h4; sa[2] = 32'h8;
    sd[0] = 32'h0101_0101; sd[1] = 32'h0202_0202; sd[2] = 32'h0303_0303;
    for (int i = 0; i < 3; i++) begin
      store(sa[i], sd[i], 4'b1111, 32'h200 + 32'(i * 4));
      step();
      check("b2b_tv", 32'(trace_valid), 32'd1);
      check("b2b_taddr", trace_addr, sa[i]);
      check("b2b_tpc", trace_pc, 32'h200 + 32'(i * 4));
    end
    m_data_byteen = 4'b0000;
    step();
    check("b2b_end_tv", 32'(trace_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      m_data_addr = sa[i];
      #1 check("b2b_rd", m_data_rdata, sd[i]);
    end

    // Reset mid-clear at clr_ptr = 7
    reset = 1'b0;
    #1 check("rst2_busy", 32'(busy), 32'd1);
    check("rst2_oor", 32'(oor_err), 32'd0);
    check("rst2_tdata", trace_data, 32'h0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 7; i++) step();
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1 check("rst3_busy", 32'(busy), 32'd1);
    step();
    reset = 1'b1;
    wait_clear("clear_restart");
    m_data_addr = 32'h10;
    #1 check("restart_w4", m_data_rdata, 32'h0);

    // Reset during a READY store
    store(32'h20, 32'h5A5A_5A5A, 4'b1111, 32'h300);
    #1 reset = 1'b0;
    #1 check("rst4_busy", 32'(busy), 32'd1);
    step();
    check("rst4_tv", 32'(trace_valid), 32'd0);
    check("rst4_tpc", trace_pc, 32'h0);
    m_data_byteen = 4'b0000;
    reset = 1'b1;
    wait_clear("clear_after_store");
    m_data_addr = 32'h20;
    #1 check("lost_store", m_data_rdata, 32'h0);
    check("rst4_oor", 32'(oor_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
